// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester, response and memory-side signals of mem_bus_arbiter
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter/sequencer for the shared single-ported memory bus
module mem_bus_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.slave  bus,
    output logic              busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      LAT_INIT = CW'(RD_LAT);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic          grant_valid;
    logic          handshake;
    logic          we_q;
    logic [CW-1:0] wait_cnt;

    // First valid requester at or after last_grant+1, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_valid && bus.req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign handshake = (state == IDLE) && grant_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    if (rst_n) begin
                        bus.req_ready = REQ_ONE << grant_idx;
                    end
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_we = we_q;
                bus.mem_re = !we_q;
                state_nxt  = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == CNT_ONE) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = REQ_ONE << owner;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // mem_addr/mem_wdata double as the captured request payload, so they hold between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= LAST_IDX;
            owner         <= '0;
            we_q          <= 1'b0;
            wait_cnt      <= '0;
            bus.rsp_rdata <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (handshake) begin
                last_grant    <= grant_idx;
                owner         <= grant_idx;
                we_q          <= bus.req_we[grant_idx];
                bus.mem_addr  <= bus.req_addr[32*grant_idx +: 32];
                bus.mem_wdata <= bus.req_wdata[32*grant_idx +: 32];
            end
            if (state == ACCESS) begin
                wait_cnt <= LAT_INIT;
                if (we_q) begin
                    bus.rsp_rdata <= '0;
                end
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt - CNT_ONE;
                if (wait_cnt == CNT_ONE) begin
                    bus.rsp_rdata <= bus.mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter (RD_LAT=1 main instance, RD_LAT=4 latency instance)
module tb_mem_bus_arbiter;
    localparam int N  = 3;
    localparam int L1 = 1;
    localparam int L4 = 4;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy1;
    logic busy4;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_arbiter_if #(.NUM_REQ(N)) bus1 ();
    mem_bus_arbiter_if #(.NUM_REQ(N)) bus4 ();

    mem_bus_arbiter #(.NUM_REQ(N), .RD_LAT(L1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1),
        .busy  (busy1)
    );

    mem_bus_arbiter #(.NUM_REQ(N), .RD_LAT(L4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4),
        .busy  (busy4)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory models: data appears exactly RD_LAT cycles after mem_re, garbage otherwise.
    logic [31:0] p1;
    logic [31:0] p4 [L4];
    always @(posedge clk) begin
        p1 <= bus1.mem_re ? memf(bus1.mem_addr) : BAD;
        p4[0] <= bus4.mem_re ? memf(bus4.mem_addr) : BAD;
        for (int k = 1; k < L4; k++) p4[k] <= p4[k-1];
    end
    assign bus1.mem_rdata = p1;
    assign bus4.mem_rdata = p4[L4-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference: the bus is free again at m_free; each accept schedules its events.
    typedef struct { int cyc; logic [N-1:0] v; } rdy_t;
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } mem_t;
    typedef struct { int cyc; logic [N-1:0] v; logic [31:0] data; } rsp_t;
    rdy_t rdy_q [$];
    mem_t mem_q [$];
    rsp_t rsp_q [$];
    int   m_ptr = N - 1;
    int   m_free = 0;
    int   m_acc = -10;

    always @(negedge clk) begin : model
        int w;
        int best;
        int d;
        int rc;
        logic [N-1:0] oh;
        logic [31:0] a;
        logic [31:0] wd;
        logic we;
        if (!rst_n) begin
            rdy_q.delete();
            mem_q.delete();
            rsp_q.delete();
            m_ptr  = N - 1;
            m_free = 0;
            m_acc  = -10;
        end else if (cyc >= m_free && bus1.req_valid != '0) begin
            w = 0;
            best = N + 1;
            for (int i = 0; i < N; i++) begin
                if (bus1.req_valid[i]) begin
                    d = (i - m_ptr - 1 + 2 * N) % N;
                    if (d < best) begin
                        best = d;
                        w = i;
                    end
                end
            end
            a  = bus1.req_addr[32*w +: 32];
            wd = bus1.req_wdata[32*w +: 32];
            we = bus1.req_we[w];
            oh = '0;
            oh[w] = 1'b1;
            rc = we ? cyc + 2 : cyc + 2 + L1;
            rdy_q.push_back('{cyc, oh});
            mem_q.push_back('{cyc + 1, we, a, wd});
            rsp_q.push_back('{rc, oh, we ? 32'h0 : memf(a)});
            m_acc  = cyc;
            m_free = rc + 1;
            m_ptr  = w;
        end
    end

    always begin : monitor
        rdy_t r;
        mem_t m;
        rsp_t s;
        @(negedge clk);
        #2;
        if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
            r = rdy_q.pop_front();
            chk("req_ready", bus1.req_ready, r.v);
        end else begin
            chk("req_ready_idle", bus1.req_ready, 0);
        end
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
            m = mem_q.pop_front();
            chk("mem_we", bus1.mem_we, m.we);
            chk("mem_re", bus1.mem_re, !m.we);
            chk("mem_addr", bus1.mem_addr, m.addr);
            chk("mem_wdata", bus1.mem_wdata, m.wdata);
        end else begin
            chk("mem_strobe_idle", {bus1.mem_we, bus1.mem_re}, 0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            s = rsp_q.pop_front();
            chk("rsp_valid", bus1.rsp_valid, s.v);
            chk("rsp_rdata", bus1.rsp_rdata, s.data);
        end else begin
            chk("rsp_valid_idle", bus1.rsp_valid, 0);
        end
        chk("busy", busy1, (cyc > m_acc) && (cyc < m_free));
    end

    int glog_idx [$];
    int glog_cyc [$];
    int cafe_hits = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (bus1.req_valid[i] && bus1.req_ready[i]) begin
                    glog_idx.push_back(i);
                    glog_cyc.push_back(cyc);
                end
            end
            if ((bus1.mem_we || bus1.mem_re) && bus1.mem_addr == 32'h000C_AFE0) cafe_hits++;
        end
    end

    logic [N-1:0] acc;
    int acc_cyc;

    task automatic step();
        @(negedge clk);
        acc = bus1.req_valid & bus1.req_ready;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus1.req_we[i] = we;
        bus1.req_addr[32*i +: 32] = a;
        bus1.req_wdata[32*i +: 32] = wd;
        bus1.req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i, input int maxc);
        logic got;
        got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            step();
            if (acc[i]) begin
                got = 1'b1;
                bus1.req_valid[i] = 1'b0;
            end
        end
        chk("accept_timeout", got, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t4;
        int twos;
        bus1.req_valid = '1;
        bus1.req_we    = '0;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus4.req_valid = '0;
        bus4.req_we    = '0;
        bus4.req_addr  = '0;
        bus4.req_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus1.req_ready, 0);
        chk("rst_rsp_valid", bus1.rsp_valid, 0);
        chk("rst_rsp_rdata", bus1.rsp_rdata, 0);
        chk("rst_mem_addr", bus1.mem_addr, 0);
        chk("rst_mem_wdata", bus1.mem_wdata, 0);
        chk("rst_strobes", {bus1.mem_we, bus1.mem_re}, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_busy4", busy4, 0);
        bus1.req_valid = '0;
        rst_n = 1'b1;
        idle(2);

        issue(1, 1'b0, 32'h40, 32'h0);
        wait_accept(1, 10);
        idle(5);
        issue(0, 1'b1, 32'h8000, 32'h1234);
        wait_accept(0, 10);
        idle(5);

        bus4.req_addr[31:0] = 32'h10;
        bus4.req_we[0] = 1'b0;
        bus4.req_valid[0] = 1'b1;
        @(negedge clk);
        chk("lat_ready", bus4.req_ready, 3'b001);
        t4 = cyc;
        @(posedge clk);
        #1;
        bus4.req_valid[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("lat_busy", busy4, k <= 6);
            chk("lat_mem_re", bus4.mem_re, k == 1);
            if (k == 1) chk("lat_mem_addr", bus4.mem_addr, 32'h10);
            chk("lat_rsp_valid", bus4.rsp_valid, (k == 6) ? 3'b001 : 3'b000);
            if (k == 6) chk("lat_rsp_rdata", bus4.rsp_rdata, memf(32'h10));
        end
        @(posedge clk);
        #1;

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        glog_idx.delete();
        glog_cyc.delete();
        for (int i = 0; i < N; i++) issue(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
        for (int k = 0; k < 40 && glog_idx.size() < 6; k++) begin
            step();
            for (int i = 0; i < N; i++) if (acc[i]) issue(i, 1'b0, 32'h180 + 32'(k * 4), 32'h0);
        end
        bus1.req_valid = '0;
        chk("contention_count", glog_idx.size(), 6);
        for (int k = 0; k < 6 && k < glog_idx.size(); k++) begin
            chk("contention_order", glog_idx[k], k % 3);
            if (k > 0) chk("contention_spacing", glog_cyc[k] - glog_cyc[k-1], 4);
        end
        idle(6);

        glog_idx.delete();
        cafe_hits = 0;
        issue(0, 1'b0, 32'h200, 32'h0);
        wait_accept(0, 10);
        issue(2, 1'b0, 32'h000C_AFE0, 32'h0);
        step();
        step();
        bus1.req_valid[2] = 1'b0;
        idle(6);
        twos = 0;
        foreach (glog_idx[k]) if (glog_idx[k] == 2) twos++;
        chk("withdrawn_grants", twos, 0);
        chk("withdrawn_strobes", cafe_hits, 0);

        issue(2, 1'b0, 32'h400, 32'h0);
        wait_accept(2, 10);
        chk("pre_reset_re", bus1.mem_re, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_access_re", bus1.mem_re, 1'b0);
        chk("reset_access_busy", busy1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        issue(1, 1'b0, 32'h300, 32'h0);
        wait_accept(1, 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_wait_busy", busy1, 1'b0);
        chk("reset_wait_rsp", bus1.rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) issue(i, 1'b0, 32'h500 + 32'(i * 4), 32'h0);
        step();
        chk("first_after_reset", acc, 3'b001);
        bus1.req_valid = '0;
        idle(6);

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (bus1.req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) bus1.req_valid[i] = 1'b0;
                    else if ($urandom_range(0, 7) == 0) issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if ($urandom_range(0, 2) == 0) begin
                    issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
            step();
            for (int i = 0; i < N; i++) if (acc[i]) bus1.req_valid[i] = 1'b0;
        end
        bus1.req_valid = '0;
        idle(10);
        chk("drain_rsp", rsp_q.size(), 0);
        chk("drain_mem", mem_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and sequencer for the SoC's single-ported memory/peripheral bus. It shares one 32-bit word port among several requesters: CPU instruction fetch, CPU load/store and the audio sample DMA. The requesters sit upstream of the arbiter, and the SRAM and audio PWM register decode sit downstream. It runs one transaction at a time, with no pipelining. It hides the fixed read latency of the memory behind a valid/ready request channel and a per-requester response pulse.

## Interface
- NUM_REQ, 3: number of requesters (2..8); index 0 = audio DMA, 1 = CPU data, 2 = CPU fetch
- RD_LAT, 1: memory read latency in cycles (1..8)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_addr  in  32*NUM_REQ  word address; requester i at bits [32i+31:32i]
- req_wdata  in  32*NUM_REQ  write data, same packing
- req_we  in  NUM_REQ  1 = write, 0 = read
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  32  read data, shared; meaningful only with rsp_valid
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  32  bus read data, valid RD_LAT cycles after mem_re
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req_valid is high, the winner is the first set bit searching upward, with wrap, from (last_grant+1) mod NUM_REQ.
  - req_ready[winner] is high combinationally in IDLE only.
  - When a valid&ready handshake occurs, the arbiter registers addr, wdata and we, stores the owner index, sets last_grant to the winner and moves to ACCESS.
- ACCESS (1 cycle): mem_addr and mem_wdata come from the registered values. mem_we = we and mem_re = !we. Next state is RESP for a write, WAIT for a read.
- WAIT (RD_LAT cycles, down-counter): in the last WAIT cycle the arbiter samples mem_rdata into rsp_rdata. Next state is RESP.
- RESP (1 cycle): rsp_valid[owner] = 1. rsp_rdata holds the read data for a read and is 0 for a write. Next state is IDLE.
- Outside ACCESS, mem_we = mem_re = 0. mem_addr and mem_wdata hold their last value.
- Requester rules:
  - A requester holds valid and its payload stable until ready.
  - Dropping valid before ready is legal; the request is simply not accepted.
  - Payload changes while not ready are legal and are not captured.
- Round-robin fairness: a continuously asserted requester waits at most NUM_REQ-1 transactions.
- Addresses and data pass through unmodified; the arbiter does no address decode.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_REQ-1 (so requester 0 wins first)
  - req_ready = 0 while rst_n is low
  - rsp_valid = 0, rsp_rdata = 0
  - mem_addr = 0, mem_wdata = 0, mem_we = 0, mem_re = 0
  - busy = 0
- Handshake at cycle T:
  - ACCESS at T+1.
  - Write: rsp_valid at T+2; next accept possible at T+3.
  - Read: WAIT spans T+2..T+1+RD_LAT; rsp_valid at T+2+RD_LAT; next accept at T+3+RD_LAT.
  - With RD_LAT=1: read response at T+3, one transaction every 4 cycles.
- req_ready is 0 in ACCESS, WAIT and RESP, including the RESP cycle. New requests wait until IDLE.
- Simultaneous req_valid on all requesters: exactly one ready bit is set, chosen by the pointer.
- A request arriving in RESP is accepted in the following IDLE cycle.
- Reset asserted mid-transaction:
  - The transaction aborts immediately and asynchronously.
  - No rsp_valid is produced, and mem_we/mem_re drop at once.
  - After release, arbitration restarts from requester 0.
- The pointer wraps from NUM_REQ-1 to 0.
- The WAIT counter reloads with RD_LAT on every ACCESS→WAIT transition.

## Test plan
- Reset then single read: requester 1 reads addr 0x40 (memory model returns 0xDEADBEEF, RD_LAT=1), handshake at T -> mem_re=1 with mem_addr=0x40 at T+1, rsp_valid[1]=1 with rsp_rdata=0xDEADBEEF at T+3, other rsp bits 0.
- Single write: requester 0 writes 0x1234 to 0x8000 -> mem_we=1, mem_addr=0x8000, mem_wdata=0x1234 for exactly one cycle at T+1; rsp_valid[0] at T+2 with rsp_rdata=0.
- Contention: all three requesters hold valid with reads from reset -> grants in order 0,1,2,0,1,2 at 4-cycle spacing; each rsp_valid goes only to its owner.
- Latency sweep: RD_LAT=4, read 0x10 -> WAIT lasts 4 cycles, mem_rdata sampled in the last WAIT cycle, rsp_valid at T+6; busy high T+1..T+6.
- Withdrawn request: requester 2 raises valid in ACCESS of another transaction and drops it before IDLE -> never granted; no mem strobe for its address.
- Reset mid-read: assert rst_n=0 during WAIT -> rsp_valid stays 0; after release, requester 0 is granted first when all requesters are valid.
